// File: rtl/sm3_arb_pkg.sv
// Shared types and helpers for the SM3 message arbiter.
package sm3_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    WAIT   = 2'd2
  } arb_state_e;

  // Largest supported requester count and the index width that covers it.
  localparam int MAX_REQ = 8;
  localparam int PICK_W  = 3;

  // Requester ID width for a given requester count, never below one bit.
  function automatic int id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // Round-robin pick: first set bit of req at or above ptr, wrapping at num_req.
  function automatic logic [PICK_W-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                input logic [PICK_W-1:0]  ptr,
                                                input int                 num_req);
    logic [PICK_W-1:0] sel;
    logic              found;
    logic [3:0]        idx;
    sel   = ptr;
    found = 1'b0;
    for (int off = 0; off < MAX_REQ; off++) begin
      idx = {1'b0, ptr} + 4'(off);
      if (idx >= 4'(num_req)) idx = idx - 4'(num_req);
      if (off < num_req && !found && req[idx[2:0]]) begin
        sel   = idx[2:0];
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/sm3_msg_arb.sv
// Round-robin arbiter sharing one SM3 pad core between NUM_REQ message requesters.
// A requester owns the core from its first beat through the lst beat and, when
// WAIT_DONE is set, until the core reports the digest, which is routed back to it.
module sm3_msg_arb
  import sm3_arb_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int INPT_DW   = 32,
  parameter int WAIT_DONE = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ*INPT_DW-1:0]      req_d_i,
  input  logic [NUM_REQ*(INPT_DW/8)-1:0]  req_vld_byte_i,
  input  logic [NUM_REQ-1:0]              req_vld_i,
  input  logic [NUM_REQ-1:0]              req_lst_i,
  output logic [NUM_REQ-1:0]              req_rdy_o,
  output logic [INPT_DW-1:0]              msg_inpt_d_o,
  output logic [INPT_DW/8-1:0]            msg_inpt_vld_byte_o,
  output logic                            msg_inpt_vld_o,
  output logic                            msg_inpt_lst_o,
  input  logic                            msg_inpt_rdy_i,
  input  logic                            hash_done_i,
  output logic [NUM_REQ-1:0]              hash_done_o,
  output logic [id_width(NUM_REQ)-1:0]    gnt_id_o,
  output logic                            busy_o,
  output logic                            err_o
);

  localparam int ID_W = id_width(NUM_REQ);
  localparam int BW   = INPT_DW / 8;

  arb_state_e        state, state_nxt;
  logic [ID_W-1:0]   gnt_id;
  logic [ID_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] done_q;
  logic              busy_q;
  logic              err_q;
  logic [PICK_W-1:0] pick;
  logic              lst_xfer;

  assign pick     = rr_pick(MAX_REQ'(req_vld_i), PICK_W'(rr_ptr), NUM_REQ);
  assign lst_xfer = msg_inpt_vld_o && msg_inpt_rdy_i && msg_inpt_lst_o;

  // Next-state decode plus the data mux and per-requester ready steering.
  // NOTE: every output gets a default before the case so no path leaves a latch.
  always_comb begin
    state_nxt           = state;
    req_rdy_o           = '0;
    msg_inpt_vld_o      = 1'b0;
    msg_inpt_lst_o      = 1'b0;
    msg_inpt_d_o        = req_d_i[int'(gnt_id)*INPT_DW +: INPT_DW];
    msg_inpt_vld_byte_o = req_vld_byte_i[int'(gnt_id)*BW +: BW];
    case (state)
      IDLE: begin
        if (|req_vld_i) state_nxt = STREAM;
      end
      STREAM: begin
        msg_inpt_vld_o    = req_vld_i[gnt_id];
        msg_inpt_lst_o    = req_lst_i[gnt_id];
        req_rdy_o[gnt_id] = msg_inpt_rdy_i;
        if (msg_inpt_vld_o && msg_inpt_rdy_i && msg_inpt_lst_o)
          state_nxt = (WAIT_DONE != 0) ? WAIT : IDLE;
      end
      WAIT: begin
        if (hash_done_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, owner, round-robin pointer, completion pulse and sticky error.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      gnt_id <= '0;
      rr_ptr <= '0;
      done_q <= '0;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt != IDLE);
      done_q <= '0;
      if (state == IDLE && |req_vld_i)
        gnt_id <= ID_W'(pick);
      if (lst_xfer)
        rr_ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
      if (state == WAIT && hash_done_i)
        done_q <= NUM_REQ'(1) << gnt_id;
      // A digest outside WAIT cannot belong to anyone; only IDLE without WAIT_DONE is benign.
      if (hash_done_i && (state == STREAM || (state == IDLE && WAIT_DONE != 0)))
        err_q <= 1'b1;
    end
  end

  assign hash_done_o = done_q;
  assign gnt_id_o    = gnt_id;
  assign busy_o      = busy_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_sm3_msg_arb.sv
// Self-checking bench for sm3_msg_arb: a 2-requester WAIT_DONE=1 instance and a
// 4-requester WAIT_DONE=0 instance, each compared every cycle against a
// transaction-level model, plus literal expectations for the directed scenarios.
module tb_sm3_msg_arb;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  vb;
    logic        lst;
  } beat_t;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  vb;
    logic        lst;
    logic [2:0]  own;
    logic [31:0] cyc;
  } rec_t;

  int n_req [2] = '{2, 4};
  bit wd    [2] = '{1'b1, 1'b0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus, indexed by instance
  logic [7:0]  s_vld [2];
  logic [7:0]  s_lst [2];
  logic [31:0] s_d   [2][8];
  logic [3:0]  s_vb  [2][8];
  logic        s_rdy [2];
  logic        s_done[2];
  logic        s_rst [2];

  logic [63:0]  d0;
  logic [7:0]   vb0;
  logic [127:0] d1;
  logic [15:0]  vb1;
  assign d0  = {s_d[0][1], s_d[0][0]};
  assign vb0 = {s_vb[0][1], s_vb[0][0]};
  assign d1  = {s_d[1][3], s_d[1][2], s_d[1][1], s_d[1][0]};
  assign vb1 = {s_vb[1][3], s_vb[1][2], s_vb[1][1], s_vb[1][0]};

  logic [1:0]  o0_rdy, o0_done;
  logic [31:0] o0_d;
  logic [3:0]  o0_vb;
  logic        o0_vld, o0_lst, o0_busy, o0_err;
  logic [0:0]  o0_gnt;
  logic [3:0]  o1_rdy, o1_done;
  logic [31:0] o1_d;
  logic [3:0]  o1_vb;
  logic        o1_vld, o1_lst, o1_busy, o1_err;
  logic [1:0]  o1_gnt;

  sm3_msg_arb #(.NUM_REQ(2), .INPT_DW(32), .WAIT_DONE(1)) u_dut0 (
    .clk(clk), .rst(s_rst[0]),
    .req_d_i(d0), .req_vld_byte_i(vb0), .req_vld_i(s_vld[0][1:0]), .req_lst_i(s_lst[0][1:0]),
    .req_rdy_o(o0_rdy),
    .msg_inpt_d_o(o0_d), .msg_inpt_vld_byte_o(o0_vb), .msg_inpt_vld_o(o0_vld),
    .msg_inpt_lst_o(o0_lst), .msg_inpt_rdy_i(s_rdy[0]),
    .hash_done_i(s_done[0]), .hash_done_o(o0_done),
    .gnt_id_o(o0_gnt), .busy_o(o0_busy), .err_o(o0_err)
  );

  sm3_msg_arb #(.NUM_REQ(4), .INPT_DW(32), .WAIT_DONE(0)) u_dut1 (
    .clk(clk), .rst(s_rst[1]),
    .req_d_i(d1), .req_vld_byte_i(vb1), .req_vld_i(s_vld[1][3:0]), .req_lst_i(s_lst[1][3:0]),
    .req_rdy_o(o1_rdy),
    .msg_inpt_d_o(o1_d), .msg_inpt_vld_byte_o(o1_vb), .msg_inpt_vld_o(o1_vld),
    .msg_inpt_lst_o(o1_lst), .msg_inpt_rdy_i(s_rdy[1]),
    .hash_done_i(s_done[1]), .hash_done_o(o1_done),
    .gnt_id_o(o1_gnt), .busy_o(o1_busy), .err_o(o1_err)
  );

  // DUT outputs widened to a common shape
  logic [7:0]  a_rdy[2], a_done[2];
  logic [31:0] a_d[2], a_gnt[2];
  logic [3:0]  a_vb[2];
  logic        a_vld[2], a_lst[2], a_busy[2], a_err[2];
  always_comb begin
    a_rdy[0]  = {6'd0, o0_rdy};   a_rdy[1]  = {4'd0, o1_rdy};
    a_done[0] = {6'd0, o0_done};  a_done[1] = {4'd0, o1_done};
    a_d[0]    = o0_d;             a_d[1]    = o1_d;
    a_vb[0]   = o0_vb;            a_vb[1]   = o1_vb;
    a_vld[0]  = o0_vld;           a_vld[1]  = o1_vld;
    a_lst[0]  = o0_lst;           a_lst[1]  = o1_lst;
    a_busy[0] = o0_busy;          a_busy[1] = o1_busy;
    a_err[0]  = o0_err;           a_err[1]  = o1_err;
    a_gnt[0]  = {31'd0, o0_gnt};  a_gnt[1]  = {30'd0, o1_gnt};
  end

  // Requester queues (index inst*8+req), observed transfers and grant order
  beat_t rq   [16][$];
  rec_t  olog [2][$];
  int    glog [2][$];

  // Reference model: 0 idle, 1 streaming, 2 waiting for digest
  int          m_st[2], m_own[2], m_ptr[2];
  logic [7:0]  m_done[2];
  logic        m_err[2];
  logic        hold_v[2];
  logic [31:0] hold_d[2];

  int done_cnt[16];
  int done_cyc[2];
  logic done_busy[2];

  int rdy_mode[2];
  int rdy_pat[$];
  int done_at[2], auto_lat[2], wait_cnt[2];
  bit done_on_lst[2], rst_req[2];

  int cyc;
  int checks;
  int errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int d, input int k, input logic [31:0] data,
                      input logic [3:0] vb, input logic lst);
    beat_t b;
    b.d = data; b.vb = vb; b.lst = lst;
    rq[d*8+k].push_back(b);
  endtask

  task automatic mreset(input int d);
    m_st[d] = 0; m_own[d] = 0; m_ptr[d] = 0; m_done[d] = '0; m_err[d] = 1'b0;
    hold_v[d] = 1'b0; wait_cnt[d] = 0; done_on_lst[d] = 1'b0;
    for (int k = 0; k < 8; k++) rq[d*8+k].delete();
  endtask

  task automatic drive(input int d);
    int o;
    s_rst[d] = rst_req[d];
    for (int k = 0; k < 8; k++) begin
      if (k < n_req[d] && rq[d*8+k].size() > 0) begin
        s_vld[d][k] = 1'b1;
        s_d[d][k]   = rq[d*8+k][0].d;
        s_vb[d][k]  = rq[d*8+k][0].vb;
        s_lst[d][k] = rq[d*8+k][0].lst;
      end else begin
        s_vld[d][k] = 1'b0;
        s_d[d][k]   = $urandom;
        s_vb[d][k]  = 4'($urandom);
        s_lst[d][k] = 1'($urandom);
      end
    end
    case (rdy_mode[d])
      1: s_rdy[d] = 1'($urandom_range(0, 1));
      2: if (m_st[d] == 1 && rdy_pat.size() > 0) s_rdy[d] = 1'(rdy_pat.pop_front());
         else s_rdy[d] = 1'b1;
      default: s_rdy[d] = 1'b1;
    endcase
    s_done[d] = (cyc == done_at[d]);
    if (auto_lat[d] > 0 && m_st[d] == 2) begin
      wait_cnt[d]++;
      if (wait_cnt[d] >= auto_lat[d]) s_done[d] = 1'b1;
    end else begin
      wait_cnt[d] = 0;
    end
    o = m_own[d];
    if (done_on_lst[d] && m_st[d] == 1 && s_vld[d][o] && s_rdy[d] && s_lst[d][o]) begin
      s_done[d]      = 1'b1;
      done_on_lst[d] = 1'b0;
    end
  endtask

  // Compare one instance against the model, then advance the model by one edge.
  task automatic cmp(input int d);
    int o, n, k;
    logic [7:0] e_rdy;
    logic e_vld, e_lst;
    string p;
    rec_t r;
    n = n_req[d]; o = m_own[d]; p = $sformatf("dut%0d", d);
    e_rdy = '0; e_vld = 1'b0; e_lst = 1'b0;
    if (m_st[d] == 1) begin
      e_vld    = s_vld[d][o];
      e_lst    = s_lst[d][o];
      e_rdy[o] = s_rdy[d];
    end
    check({p, ".busy"}, 32'(a_busy[d]), 32'(m_st[d] != 0));
    check({p, ".gnt"},  a_gnt[d], 32'(m_own[d]));
    check({p, ".done"}, 32'(a_done[d]), 32'(m_done[d]));
    check({p, ".err"},  32'(a_err[d]), 32'(m_err[d]));
    check({p, ".vld"},  32'(a_vld[d]), 32'(e_vld));
    check({p, ".lst"},  32'(a_lst[d]), 32'(e_lst));
    check({p, ".rdy"},  32'(a_rdy[d]), 32'(e_rdy));
    if (e_vld) begin
      check({p, ".data"}, a_d[d], rq[d*8+o][0].d);
      check({p, ".vbyte"}, 32'(a_vb[d]), 32'(rq[d*8+o][0].vb));
    end
    if (hold_v[d]) check({p, ".stall_data"}, a_d[d], hold_d[d]);
    hold_v[d] = a_vld[d] && !s_rdy[d] && !s_rst[d];
    hold_d[d] = a_d[d];
    for (k = 0; k < n; k++) begin
      if (s_vld[d][k] && a_rdy[d][k]) begin
        r.d = rq[d*8+k][0].d; r.vb = rq[d*8+k][0].vb; r.lst = rq[d*8+k][0].lst;
        r.own = 3'(k); r.cyc = 32'(cyc);
        olog[d].push_back(r);
        void'(rq[d*8+k].pop_front());
      end
      if (a_done[d][k]) begin
        done_cnt[d*8+k]++;
        done_cyc[d]  = cyc;
        done_busy[d] = a_busy[d];
      end
    end
    if (s_rst[d]) begin
      mreset(d);
    end else begin
      m_done[d] = '0;
      case (m_st[d])
        0: begin
          if (s_done[d] && wd[d]) m_err[d] = 1'b1;
          for (int off = n - 1; off >= 0; off--)
            if (s_vld[d][(m_ptr[d] + off) % n]) m_own[d] = (m_ptr[d] + off) % n;
          if ((s_vld[d] & 8'((1 << n) - 1)) != 0) begin
            m_st[d] = 1;
            glog[d].push_back(m_own[d]);
          end
        end
        1: begin
          if (s_done[d]) m_err[d] = 1'b1;
          if (s_vld[d][o] && s_rdy[d] && s_lst[d][o]) begin
            m_ptr[d] = (o + 1) % n;
            m_st[d]  = wd[d] ? 2 : 0;
          end
        end
        default: begin
          if (s_done[d]) begin
            m_done[d] = 8'(1 << o);
            m_st[d]   = 0;
          end
        end
      endcase
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    drive(0);
    drive(1);
    #1;
    cmp(0);
    cmp(1);
  endtask

  function automatic bit quiet(input int d);
    bit q;
    q = (m_st[d] == 0) && (m_done[d] == 0);
    for (int k = 0; k < 8; k++) if (rq[d*8+k].size() != 0) q = 1'b0;
    return q;
  endfunction

  task automatic drain(input int d, input int budget);
    int i;
    i = 0;
    while (!quiet(d) && i < budget) begin
      step();
      i++;
    end
    step();
    check($sformatf("dut%0d.drain_in_budget", d), 32'(quiet(d)), 32'd1);
  endtask

  task automatic do_reset(input int d);
    rst_req[d] = 1'b1;
    step();
    rst_req[d] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, i, tot0, tot1, len, k, sum1;
    int exp2[4] = '{0, 1, 0, 1};
    int exp6[3] = '{1, 3, 1};
    checks = 0; errors = 0; cyc = 0;
    for (int d = 0; d < 2; d++) begin
      s_vld[d] = '0; s_lst[d] = '0; s_rdy[d] = 1'b1; s_done[d] = 1'b0; s_rst[d] = 1'b1;
      for (int j = 0; j < 8; j++) begin s_d[d][j] = '0; s_vb[d][j] = '0; end
      rdy_mode[d] = 0; done_at[d] = -1; auto_lat[d] = 0; rst_req[d] = 1'b1;
      mreset(d);
    end
    for (int j = 0; j < 16; j++) done_cnt[j] = 0;
    repeat (3) @(posedge clk);
    step();
    rst_req[0] = 1'b0; rst_req[1] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("dut%0d.reset_busy", d), 32'(a_busy[d]), 32'd0);
      check($sformatf("dut%0d.reset_rdy", d),  32'(a_rdy[d]),  32'd0);
      check($sformatf("dut%0d.reset_vld", d),  32'(a_vld[d]),  32'd0);
      check($sformatf("dut%0d.reset_err", d),  32'(a_err[d]),  32'd0);
      check($sformatf("dut%0d.reset_gnt", d),  a_gnt[d],       32'd0);
    end

    // 1: single 3-beat message, digest at cycle 70
    t0 = cyc; olog[0].delete();
    push(0, 0, 32'h61626380, 4'b1110, 1'b0);
    push(0, 0, 32'h00000000, 4'b1110, 1'b0);
    push(0, 0, 32'h00000018, 4'b1110, 1'b1);
    done_at[0] = t0 + 70;
    while (cyc < t0 + 74) step();
    check("t1.nbeats", 32'(olog[0].size()), 32'd3);
    if (olog[0].size() == 3) begin
      check("t1.first_xfer_cycle", olog[0][0].cyc, 32'(t0 + 2));
      check("t1.beat0", olog[0][0].d, 32'h61626380);
      check("t1.beat1", olog[0][1].d, 32'h00000000);
      check("t1.beat2", olog[0][2].d, 32'h00000018);
      check("t1.vbyte2", 32'(olog[0][2].vb), 32'he);
      check("t1.lst2", 32'(olog[0][2].lst), 32'd1);
    end
    check("t1.done_cycle", 32'(done_cyc[0]), 32'(t0 + 71));
    check("t1.done_count", 32'(done_cnt[0]), 32'd1);
    check("t1.busy_at_done", 32'(done_busy[0]), 32'd0);
    done_at[0] = -1;

    // 2: both requesters, two 2-beat messages each, random backpressure
    do_reset(0);
    glog[0].delete(); done_cnt[0] = 0; done_cnt[1] = 0;
    for (int m = 0; m < 2; m++)
      for (int r = 0; r < 2; r++) begin
        push(0, r, $urandom, 4'hf, 1'b0);
        push(0, r, $urandom, 4'($urandom), 1'b1);
      end
    rdy_mode[0] = 1; auto_lat[0] = 2;
    drain(0, 400);
    check("t2.ngrants", 32'(glog[0].size()), 32'd4);
    if (glog[0].size() == 4)
      for (i = 0; i < 4; i++) check($sformatf("t2.grant%0d", i), 32'(glog[0][i]), 32'(exp2[i]));
    check("t2.done_req0", 32'(done_cnt[0]), 32'd2);
    check("t2.done_req1", 32'(done_cnt[1]), 32'd2);

    // 3: backpressure pattern 1,0,0,1 on a 4-beat message
    olog[0].delete();
    rdy_mode[0] = 2; rdy_pat = '{1, 0, 0, 1};
    for (i = 0; i < 4; i++) push(0, 1, 32'hA0000000 + 32'(i), 4'hf, i == 3);
    drain(0, 100);
    check("t3.nbeats", 32'(olog[0].size()), 32'd4);
    if (olog[0].size() == 4)
      for (i = 0; i < 4; i++) check($sformatf("t3.beat%0d", i), olog[0][i].d, 32'hA0000000 + 32'(i));
    rdy_mode[0] = 0;

    // 4a: digest while idle is a sticky error
    do_reset(0);
    auto_lat[0] = 0; done_at[0] = cyc + 2;
    repeat (4) step();
    check("t4.err_idle_done", 32'(a_err[0]), 32'd1);
    repeat (5) step();
    check("t4.err_sticky", 32'(a_err[0]), 32'd1);
    // 4b: digest coincident with the lst transfer
    do_reset(0);
    done_cnt[0] = 0;
    push(0, 0, 32'h11111111, 4'hf, 1'b0);
    push(0, 0, 32'h22222222, 4'hf, 1'b1);
    done_on_lst[0] = 1'b1;
    i = 0;
    while (m_st[0] != 2 && i < 50) begin step(); i++; end
    step();
    check("t4.reached_wait", 32'(a_busy[0] && a_rdy[0] == 0), 32'd1);
    check("t4.err_on_lst", 32'(a_err[0]), 32'd1);
    repeat (5) step();
    check("t4.no_done_yet", 32'(done_cnt[0]), 32'd0);
    done_at[0] = cyc + 1;
    repeat (3) step();
    check("t4.done_after_pulse", 32'(done_cnt[0]), 32'd1);
    done_at[0] = -1;

    // 5: reset in the middle of a 5-beat message from requester 1
    do_reset(0);
    auto_lat[0] = 2; olog[0].delete();
    push(0, 0, 32'h0000_00aa, 4'hf, 1'b1);
    drain(0, 50);
    for (i = 0; i < 5; i++) push(0, 1, 32'h5000_0000 + 32'(i), 4'hf, i == 4);
    i = 0;
    while (olog[0].size() < 3 && i < 50) begin step(); i++; end
    rst_req[0] = 1'b1;
    step();
    rst_req[0] = 1'b0;
    step();
    check("t5.busy", 32'(a_busy[0]), 32'd0);
    check("t5.vld",  32'(a_vld[0]),  32'd0);
    check("t5.rdy",  32'(a_rdy[0]),  32'd0);
    check("t5.gnt",  a_gnt[0],       32'd0);
    glog[0].delete();
    push(0, 0, 32'h0000_0001, 4'hf, 1'b1);
    push(0, 1, 32'h0000_0002, 4'hf, 1'b1);
    drain(0, 50);
    check("t5.ngrants", 32'(glog[0].size()), 32'd2);
    if (glog[0].size() == 2) begin
      check("t5.first_after_rst", 32'(glog[0][0]), 32'd0);
      check("t5.second_after_rst", 32'(glog[0][1]), 32'd1);
    end

    // 6: four-requester instance without digest wait, requesters 1 and 3
    olog[1].delete(); glog[1].delete();
    for (int m = 0; m < 2; m++) begin
      push(1, 1, $urandom, 4'hf, 1'b0);
      push(1, 1, $urandom, 4'hf, 1'b1);
    end
    push(1, 3, $urandom, 4'hf, 1'b0);
    push(1, 3, $urandom, 4'hf, 1'b1);
    drain(1, 100);
    check("t6.ngrants", 32'(glog[1].size()), 32'd3);
    if (glog[1].size() == 3)
      for (i = 0; i < 3; i++) check($sformatf("t6.grant%0d", i), 32'(glog[1][i]), 32'(exp6[i]));
    check("t6.nbeats", 32'(olog[1].size()), 32'd6);
    if (olog[1].size() == 6)
      check("t6.span_with_gaps", olog[1][5].cyc - olog[1][0].cyc, 32'd7);

    // 7: random traffic on both instances
    olog[0].delete(); olog[1].delete();
    rdy_mode[0] = 1; rdy_mode[1] = 1; auto_lat[0] = 3;
    tot0 = 0; tot1 = 0;
    for (int m = 0; m < 24; m++) begin
      k = $urandom_range(0, 1); len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) push(0, k, $urandom, 4'($urandom), b == len - 1);
      tot0 += len;
      k = $urandom_range(0, 3); len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) push(1, k, $urandom, 4'($urandom), b == len - 1);
      tot1 += len;
    end
    drain(0, 3000);
    drain(1, 3000);
    check("t7.beats_dut0", 32'(olog[0].size()), 32'(tot0));
    check("t7.beats_dut1", 32'(olog[1].size()), 32'(tot1));
    sum1 = 0;
    for (int j = 8; j < 16; j++) sum1 += done_cnt[j];
    check("t7.no_done_dut1", 32'(sum1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
